store_trace_buffer: RTL and testbench
=====================================

Name: store_trace_buffer

Overview:
- Observes the rv32i core's data-memory write port (memWrite, aluResult as address, writeData) as the receiving end of CPU stores.
- Captures every store into a first-word-fall-through FIFO and drains it over a valid/ready stream to a bench checker or debug sink.
- Detects a store to a fixed "tohost" address and latches a done flag plus exit code, so simulations and FPGA runs can stop on completion.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
- PTR_W, 3, log2(DEPTH).
- SEQ_W, 16, width of the store sequence number.
- TOHOST_ADDR, 32'h0000_00FC, address whose store signals program completion.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- memWrite  in  1  CPU store strobe; one store per cycle while high.
- aluResult  in  32  store byte address.
- writeData  in  32  store data.
- out_valid  out  1  head entry available.
- out_ready  in  1  sink accepts the head entry this cycle.
- out_addr  out  32  head entry address.
- out_data  out  32  head entry data.
- out_seq  out  SEQ_W  head entry sequence number.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set when any store is dropped.
- drop_count  out  8  number of dropped stores; saturates at 8'hFF.
- done  out  1  sticky; set by a store to TOHOST_ADDR.
- done_code  out  32  writeData of the tohost store.

Behaviour:
- Reset: at a rising edge with reset=1, clear the read and write pointers, count, the sequence counter, overflow, drop_count, done and done_code. out_valid is 0 and out_addr, out_data and out_seq are 0. Array contents are don't-care. A reset arriving mid-operation discards all queued entries in the same edge.
- Push request: memWrite=1 and done=0 at a rising edge.
  - The entry is {seq, aluResult, writeData}.
  - seq increments, wrapping modulo 2^SEQ_W, on every push request, whether the entry is accepted or dropped. The first entry after reset has seq=0.
- Pop: out_valid=1 and out_ready=1 at a rising edge.
- FWFT: out_* are driven from the head entry whenever count>0. A pushed entry becomes visible one cycle after its capture edge, so latency is 1. Outputs read 0 when empty.
- Full with push only: the entry is dropped, overflow is set to 1, and drop_count increments (saturating). Pointers and count are unchanged.
- Full with push and pop in the same edge: both happen, the entry is accepted, count stays at DEPTH, and there is no drop.
- Empty with push and pop: the pop is ignored because out_valid=0, the push is accepted, and count becomes 1.
- Push and pop otherwise: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Backpressure: while out_valid=1 and out_ready=0, out_addr, out_data and out_seq hold stable.
- Tohost: a push request with aluResult==TOHOST_ADDR is enqueued normally, and done and done_code=writeData are latched at the same edge.
  - After that edge, memWrite is ignored: no enqueue, no seq increment, no drop accounting.
  - The FIFO keeps draining normally.
  - done clears only on reset.
- Address match is on the full 32 bits. There is no alignment check and stores to any address are traced.

Test Plan:
- Single store: reset, then memWrite=1, aluResult=32'h0000_0010, writeData=32'hDEAD_BEEF for one cycle with out_ready=0. Next cycle: out_valid=1, out_addr=32'h10, out_data=32'hDEADBEEF, out_seq=0, count=1. Pulse out_ready: count=0, out_valid=0.
- Fill and overflow: 10 consecutive stores with data 1..10 and out_ready=0. Result: count=8, overflow=1, drop_count=2. Draining yields data 1..8 with seq 0..7 in order.
- Full with simultaneous push and pop: at count=8, apply memWrite=1 and out_ready=1 together. Result: count stays 8, overflow stays 0, and the new entry is the last popped when the FIFO is drained.
- Backpressure stability: queue 3 entries and hold out_ready=0 for 5 cycles. Result: head fields are constant. Then set out_ready=1 continuously: 3 entries in 3 cycles, then out_valid=0.
- Tohost: store 32'h0000_002A to 32'h0000_00FC, then stores to 32'h20 and 32'h24. Result: done=1, done_code=32'h2A, count=1, and the later stores are not enqueued.
- Reset mid-operation: with count=5, overflow=1 and done=1, assert reset for one cycle. Next cycle: count=0, out_valid=0, overflow=0, done=0, drop_count=0, and the next store gets seq=0.

Source files
------------

// File: rtl/store_trace_buffer_if.sv
// Trace-entry stream from the store buffer to a checker or debug sink.
// The master drives the head entry; the slave returns out_ready.
interface store_trace_buffer_if #(
  parameter int SEQ_W = 16
);
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_addr;
  logic [31:0]      out_data;
  logic [SEQ_W-1:0] out_seq;

  modport master (
    output out_valid, out_addr, out_data, out_seq,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_addr, out_data, out_seq,
    output out_ready
  );
endinterface

// File: rtl/store_trace_buffer.sv
// Traces CPU stores into a FWFT FIFO and latches done/exit code on a tohost store; latency 1 cycle.
// Backpressure: head holds while out_ready is low; stores arriving while full are dropped and counted.
module store_trace_buffer #(
  parameter int          DEPTH       = 8,
  parameter int          PTR_W       = 3,
  parameter int          SEQ_W       = 16,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_00FC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                memWrite,
  input  logic [31:0]         aluResult,
  input  logic [31:0]         writeData,
  store_trace_buffer_if.master out_if,
  output logic [PTR_W:0]      count,
  output logic                overflow,
  output logic [7:0]          drop_count,
  output logic                done,
  output logic [31:0]         done_code
);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      addr;
    logic [31:0]      data;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [SEQ_W-1:0] seq;
  logic             push_req;
  logic             pop;
  logic             full;
  logic             accept;
  logic             drop;
  entry_t           head;

  // Once done is set the core is considered finished, so further stores are invisible.
  assign push_req = memWrite && !done;
  assign full     = (count == FULL_CNT);
  assign pop      = out_if.out_valid && out_if.out_ready;
  assign accept   = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign head             = (count != '0) ? mem[rd_ptr] : '0;
  assign out_if.out_valid = (count != '0);
  assign out_if.out_addr  = head.addr;
  assign out_if.out_data  = head.data;
  assign out_if.out_seq   = head.seq;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {seq, aluResult, writeData};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      seq        <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'h00;
      done       <= 1'b0;
      done_code  <= 32'h0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Sequence numbers advance on dropped stores too, so gaps reveal losses.
      if (push_req) begin
        seq <= seq + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 1'b1;
        end
      end
      if (push_req && (aluResult == TOHOST_ADDR)) begin
        done      <= 1'b1;
        done_code <= writeData;
      end
    end
  end

endmodule

// File: tb/tb_store_trace_buffer.sv
// Self-checking bench: directed plus random stores against a queue-based reference model;
// a monitor pops the scoreboard on every stream handshake.
module tb_store_trace_buffer;

  localparam int          DEPTH  = 8;
  localparam int          SEQ_W  = 16;
  localparam logic [31:0] TOHOST = 32'h0000_00FC;

  typedef struct packed {
    logic [15:0] seq;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        memWrite;
  logic [31:0] aluResult;
  logic [31:0] writeData;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        done;
  logic [31:0] done_code;

  store_trace_buffer_if #(.SEQ_W(SEQ_W)) ifc ();

  store_trace_buffer #(
    .DEPTH(DEPTH), .PTR_W(3), .SEQ_W(SEQ_W), .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk(clk), .reset(reset), .memWrite(memWrite), .aluResult(aluResult),
    .writeData(writeData), .out_if(ifc), .count(count), .overflow(overflow),
    .drop_count(drop_count), .done(done), .done_code(done_code)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  ent_t        sb_q[$];
  int          mcount;
  logic [15:0] mseq;
  logic        mover;
  int          mdrop;
  logic        mdone;
  logic [31:0] mcode;
  ent_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mcount = 0; mseq = 16'h0; mover = 1'b0; mdrop = 0; mdone = 1'b0; mcode = 32'h0;
    sb_q.delete();
  endtask

  // Reference behaviour for one clock edge, expressed as queue occupancy rules.
  task automatic model_step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                            input logic rdy);
    bit popm = (mcount > 0) && rdy;
    bit acc  = 1'b0;
    if (mw && !mdone) begin
      if (mcount < DEPTH || popm) begin
        acc = 1'b1;
        sb_q.push_back(ent_t'{seq: mseq, addr: a, data: d});
      end else begin
        mover = 1'b1;
        if (mdrop < 255) mdrop++;
      end
      if (a == TOHOST) begin
        mdone = 1'b1;
        mcode = d;
      end
      mseq = mseq + 16'd1;
    end
    mcount = mcount + int'(acc) - int'(popm);
  endtask

  task automatic status_check();
    chk("count", 32'(count), 32'(mcount));
    chk("overflow", 32'(overflow), 32'(mover));
    chk("drop_count", 32'(drop_count), 32'(mdrop));
    chk("done", 32'(done), 32'(mdone));
    chk("done_code", done_code, mcode);
    chk("out_valid", 32'(ifc.out_valid), 32'(mcount > 0));
    if (mcount == 0) begin
      chk("empty_addr", ifc.out_addr, 32'h0);
      chk("empty_data", ifc.out_data, 32'h0);
      chk("empty_seq", 32'(ifc.out_seq), 32'h0);
    end else if (sb_q.size() > 0) begin
      chk("head_addr", ifc.out_addr, sb_q[0].addr);
      chk("head_data", ifc.out_data, sb_q[0].data);
      chk("head_seq", 32'(ifc.out_seq), 32'(sb_q[0].seq));
    end
  endtask

  task automatic cycle(input logic rst, input logic mw, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    reset = rst; memWrite = mw; aluResult = a; writeData = d; ifc.out_ready = rdy;
    if (rst) model_reset();
    else model_step(mw, a, d, rdy);
    @(posedge clk);
    #1;
    status_check();
  endtask

  // Monitor: inputs are stable at the falling edge, so a handshake seen here pops next edge.
  always @(negedge clk) begin
    if (!reset && ifc.out_valid && ifc.out_ready) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pop: got addr %h data %h, expected no entry", ifc.out_addr,
                 ifc.out_data);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pop_addr", ifc.out_addr, mon_e.addr);
        chk("pop_data", ifc.out_data, mon_e.data);
        chk("pop_seq", 32'(ifc.out_seq), 32'(mon_e.seq));
      end
    end
  end

  initial begin
    reset = 1'b1; memWrite = 1'b0; aluResult = 32'h0; writeData = 32'h0; ifc.out_ready = 1'b0;
    model_reset();

    cycle(1, 0, 0, 0, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(ifc.out_valid), 32'd0);

    // Single store then one pop.
    cycle(0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    chk("single_valid", 32'(ifc.out_valid), 32'd1);
    chk("single_addr", ifc.out_addr, 32'h10);
    chk("single_data", ifc.out_data, 32'hDEAD_BEEF);
    chk("single_seq", 32'(ifc.out_seq), 32'd0);
    chk("single_count", 32'(count), 32'd1);
    cycle(0, 0, 0, 0, 1);
    chk("single_drained", 32'(count), 32'd0);
    chk("single_novalid", 32'(ifc.out_valid), 32'd0);

    // Fill past capacity.
    cycle(1, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) cycle(0, 1, 32'h100 + 32'(4 * i), 32'(i), 0);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_overflow", 32'(overflow), 32'd1);
    chk("fill_drops", 32'(drop_count), 32'd2);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1);
    chk("fill_empty", 32'(count), 32'd0);

    // Full with simultaneous push and pop.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 32'h200 + 32'(4 * i), 32'(16 + i), 0);
    cycle(0, 1, 32'h240, 32'h99, 1);
    chk("fullpp_count", 32'(count), 32'd8);
    chk("fullpp_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 1);
    chk("fullpp_last", ifc.out_data, 32'h99);
    cycle(0, 0, 0, 0, 1);
    chk("fullpp_empty", 32'(ifc.out_valid), 32'd0);

    // Backpressure stability.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("bp_addr", ifc.out_addr, 32'h300);
      chk("bp_data", ifc.out_data, 32'hA0);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    chk("bp_drained", 32'(ifc.out_valid), 32'd0);

    // Tohost stops further tracing.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, TOHOST, 32'h2A, 0);
    cycle(0, 1, 32'h20, 32'h1, 0);
    cycle(0, 1, 32'h24, 32'h2, 0);
    chk("tohost_done", 32'(done), 32'd1);
    chk("tohost_code", done_code, 32'h2A);
    chk("tohost_count", 32'(count), 32'd1);

    // Reset mid-operation.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 32'h400 + 32'(4 * i), 32'(i), 0);
    cycle(0, 1, TOHOST, 32'h55, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    chk("mid_count", 32'(count), 32'd5);
    chk("mid_overflow", 32'(overflow), 32'd1);
    chk("mid_done", 32'(done), 32'd1);
    cycle(1, 0, 0, 0, 0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_drops", 32'(drop_count), 32'd0);
    cycle(0, 1, 32'h40, 32'h7, 0);
    chk("mid_rst_seq", 32'(ifc.out_seq), 32'd0);

    // Randomised traffic with rare tohost stores and resets.
    for (int i = 0; i < 3000; i++) begin
      logic        rr, mw, rdy;
      logic [31:0] a;
      rr  = ($urandom_range(0, 399) == 0);
      mw  = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 45);
      a   = ($urandom_range(0, 299) == 0) ? TOHOST : $urandom;
      cycle(rr, mw, a, $urandom, rdy);
    end
    for (int i = 0; i < 2 * DEPTH; i++) cycle(0, 0, 0, 0, 1);
    chk("final_empty", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
